// File: rtl/flag_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Package : flag_pkg                                                        |
// | Brief   : Flag bit positions, flags type and condition-code constants.    |
// | Rev     : 1.0                                                             |
// +---------------------------------------------------------------------------+
package flag_pkg;

    typedef logic [3:0] flags_t;
    typedef logic [3:0] cond_t;

    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

    localparam cond_t c_cond_eq = 4'd0;
    localparam cond_t c_cond_ne = 4'd1;
    localparam cond_t c_cond_cs = 4'd2;
    localparam cond_t c_cond_cc = 4'd3;
    localparam cond_t c_cond_mi = 4'd4;
    localparam cond_t c_cond_pl = 4'd5;
    localparam cond_t c_cond_vs = 4'd6;
    localparam cond_t c_cond_vc = 4'd7;
    localparam cond_t c_cond_hi = 4'd8;
    localparam cond_t c_cond_ls = 4'd9;
    localparam cond_t c_cond_ge = 4'd10;
    localparam cond_t c_cond_lt = 4'd11;
    localparam cond_t c_cond_gt = 4'd12;
    localparam cond_t c_cond_le = 4'd13;
    localparam cond_t c_cond_al = 4'd14;
    localparam cond_t c_cond_nv = 4'd15;

    // Names kept for the older single-bank flag register's callers.
    localparam cond_t c_cond_equal            = c_cond_eq;
    localparam cond_t c_cond_less             = c_cond_lt;
    localparam cond_t c_cond_greater          = c_cond_gt;
    localparam cond_t c_cond_greater_or_equal = c_cond_ge;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : cond_eval                                                        |
// | Brief  : Combinational 16-code condition decode over {N,Z,C,V}.           |
// | Rev    : 1.0                                                             |
// +---------------------------------------------------------------------------+
module cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       result
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[c_flag_n];
    assign w_z = flags[c_flag_z];
    assign w_c = flags[c_flag_c];
    assign w_v = flags[c_flag_v];

    always_comb begin
        result = 1'b0;
        case (cond)
            c_cond_eq: result = w_z;
            c_cond_ne: result = ~w_z;
            c_cond_cs: result = w_c;
            c_cond_cc: result = ~w_c;
            c_cond_mi: result = w_n;
            c_cond_pl: result = ~w_n;
            c_cond_vs: result = w_v;
            c_cond_vc: result = ~w_v;
            c_cond_hi: result = w_c & ~w_z;
            c_cond_ls: result = ~w_c | w_z;
            c_cond_ge: result = (w_n == w_v);
            c_cond_lt: result = (w_n != w_v);
            c_cond_gt: result = ~w_z & (w_n == w_v);
            c_cond_le: result = w_z | (w_n != w_v);
            c_cond_al: result = 1'b1;
            default:   result = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cond_flag_rf.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : cond_flag_rf                                                     |
// | Brief  : Multi-bank {N,Z,C,V} flag file with pending scoreboard and a     |
// |          registered branch-condition result. FLAG_RF_BYPASS_EN forwards   |
// |          same-cycle write data to a colliding read instead of stalling.  |
// | Rev    : 1.0                                                             |
// +---------------------------------------------------------------------------+
module cond_flag_rf
    import flag_pkg::*;
#(
    parameter  int NUM_SETS = 4,
    localparam int SEL_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [3:0]          wr_flags,
    input  logic                rsv_en,
    input  logic [SEL_W-1:0]    rsv_sel,
    input  logic                rd_en,
    input  logic [SEL_W-1:0]    rd_sel,
    input  logic [3:0]          rd_cond,
    output logic                stall,
    output logic                out_valid,
    output logic                out,
    output logic [NUM_SETS-1:0] pending
);

    localparam logic [SEL_W:0] c_num_sets = (SEL_W+1)'(NUM_SETS);

    flags_t              r_bank [NUM_SETS];
    logic [NUM_SETS-1:0] r_pending;
    logic                r_out;
    logic                r_out_valid;

    flags_t w_rd_flags;
    flags_t w_eval_flags;
    logic   w_rd_pend;
    logic   w_rd_in_range;
    logic   w_wr_hit;
    logic   w_stall_pend;
    logic   w_accept;
    logic   w_cond_result;

    // Select compares against in-range indices only, so out-of-range
    // write/reserve selects simply match no bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                r_bank[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_SETS; i++) begin
                if (wr_en && (wr_sel == SEL_W'(i))) begin
                    r_bank[i]    <= wr_flags;
                    r_pending[i] <= 1'b0;
                end
                if (rsv_en && (rsv_sel == SEL_W'(i))) begin
                    r_pending[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_flags = '0;
        w_rd_pend  = 1'b0;
        for (int i = 0; i < NUM_SETS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                w_rd_flags = r_bank[i];
                w_rd_pend  = r_pending[i];
            end
        end
    end

    assign w_rd_in_range = ({1'b0, rd_sel} < c_num_sets);
    assign w_wr_hit      = wr_en & (wr_sel == rd_sel);

`ifdef FLAG_RF_BYPASS_EN
    assign w_stall_pend = w_rd_pend & ~w_wr_hit;
    assign w_eval_flags = w_wr_hit ? wr_flags : w_rd_flags;
`else
    // Colliding read waits one edge so it sees the freshly stored flags.
    assign w_stall_pend = w_rd_pend | w_wr_hit;
    assign w_eval_flags = w_rd_flags;
`endif

    assign stall    = rd_en & w_rd_in_range & w_stall_pend;
    assign w_accept = rd_en & ~stall;

    cond_eval u_cond_eval (
        .cond   (rd_cond),
        .flags  (w_eval_flags),
        .result (w_cond_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out <= w_rd_in_range & w_cond_result;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_rf.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : tb_cond_flag_rf                                                  |
// | Brief  : Directed + random bench for cond_flag_rf against a table model.  |
// | Rev    : 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_cond_flag_rf;
    import flag_pkg::*;

    localparam int NS = 4;

`ifdef FLAG_RF_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       wr_en, rsv_en, rd_en;
    logic [1:0] wr_sel, rsv_sel, rd_sel;
    logic [3:0] wr_flags, rd_cond;
    logic       stall, out_valid, out;
    logic [3:0] pending;

    logic       wr_en3, rsv_en3, rd_en3;
    logic [1:0] wr_sel3, rsv_sel3, rd_sel3;
    logic [3:0] wr_flags3, rd_cond3;
    logic       stall3, out_valid3, out3;
    logic [2:0] pending3;

    cond_flag_rf #(.NUM_SETS(NS)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_flags(wr_flags),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_cond(rd_cond),
        .stall(stall), .out_valid(out_valid), .out(out), .pending(pending)
    );

    cond_flag_rf #(.NUM_SETS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en3), .wr_sel(wr_sel3), .wr_flags(wr_flags3),
        .rsv_en(rsv_en3), .rsv_sel(rsv_sel3),
        .rd_en(rd_en3), .rd_sel(rd_sel3), .rd_cond(rd_cond3),
        .stall(stall3), .out_valid(out_valid3), .out(out3), .pending(pending3)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_flags [NS];
    logic [3:0] m_pend;
    logic       m_out;
    logic       m_valid;
    logic       last_stall;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pairs of codes share a base predicate; the odd code is its negation.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_flags[i] = 4'h0;
        m_pend  = 4'h0;
        m_out   = 1'b0;
        m_valid = 1'b0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic we, input logic [1:0] ws, input logic [3:0] wf,
                        input logic re, input logic [1:0] rvs,
                        input logic rd, input logic [1:0] rs, input logic [3:0] rc);
        logic hit, exp_stall;
        wr_en = we; wr_sel = ws; wr_flags = wf;
        rsv_en = re; rsv_sel = rvs;
        rd_en = rd; rd_sel = rs; rd_cond = rc;
        #1;
        hit       = we && (ws == rs);
        exp_stall = rd && (c_bypass ? (m_pend[rs] && !hit) : (m_pend[rs] || hit));
        check_val("stall", stall, exp_stall);
        last_stall = stall;
        m_valid = rd && !exp_stall;
        if (m_valid) m_out = model_cond(rc, (c_bypass && hit) ? wf : m_flags[rs]);
        if (we) begin
            m_flags[ws] = wf;
            m_pend[ws]  = 1'b0;
        end
        if (re) m_pend[rvs] = 1'b1;
        @(posedge clk);
        #1;
        check_val("out_valid", out_valid, m_valid);
        check_val("out", out, m_out);
        check_val("pending", pending, m_pend);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 4'h0);
    endtask

    task automatic rd(input logic [1:0] s, input logic [3:0] c);
        step(1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1, s, c);
    endtask

    task automatic wr(input logic [1:0] s, input logic [3:0] f);
        step(1'b1, s, f, 1'b0, 2'd0, 1'b0, 2'd0, 4'h0);
    endtask

    task automatic rsv(input logic [1:0] s);
        step(1'b0, 2'd0, 4'h0, 1'b1, s, 1'b0, 2'd0, 4'h0);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 0; wr_sel = 0; wr_flags = 0; rsv_en = 0; rsv_sel = 0;
        rd_en = 0; rd_sel = 0; rd_cond = 0;
        wr_en3 = 0; wr_sel3 = 0; wr_flags3 = 0; rsv_en3 = 0; rsv_sel3 = 0;
        rd_en3 = 0; rd_sel3 = 0; rd_cond3 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("reset_pending", pending, 4'h0);
        check_val("reset_out", out, 1'b0);
        check_val("reset_valid", out_valid, 1'b0);

        // Mid-run reset drops a reservation.
        rsv(2'd2);
        check_val("rsv_bank2", pending, 4'b0100);
        rst = 1'b1;
        #1;
        check_val("midrst_pending", pending, 4'h0);
        check_val("midrst_out", out, 1'b0);
        check_val("midrst_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rd(2'd2, c_cond_ge);
        check_val("ge_after_reset", out, 1'b1);

        // Write then read.
        wr(2'd1, 4'b0100);
        rd(2'd1, c_cond_eq);
        check_val("eq_out", out, 1'b1);
        check_val("eq_valid", out_valid, 1'b1);
        rd(2'd1, c_cond_ne);
        check_val("ne_out", out, 1'b0);

        // Scoreboard stall until the write arrives.
        rsv(2'd3);
        for (int i = 0; i < 3; i++) begin
            rd(2'd3, c_cond_lt);
            check_val("sb_stall", last_stall, 1'b1);
            check_val("sb_valid", out_valid, 1'b0);
        end
        step(1'b1, 2'd3, 4'b1000, 1'b0, 2'd0, 1'b1, 2'd3, c_cond_lt);
        if (!out_valid) rd(2'd3, c_cond_lt);
        check_val("sb_done_valid", out_valid, 1'b1);
        check_val("sb_done_out", out, 1'b1);

        // Collision of write and read on a pending bank.
        rsv(2'd3);
        step(1'b1, 2'd3, 4'b0010, 1'b0, 2'd0, 1'b1, 2'd3, c_cond_cs);
        check_val("coll_stall", last_stall, !c_bypass);
        if (!c_bypass) rd(2'd3, c_cond_cs);
        check_val("coll_valid", out_valid, 1'b1);
        check_val("coll_out", out, 1'b1);

        // Reserve and write on the same edge: reservation wins.
        step(1'b1, 2'd0, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd0, 4'h0);
        check_val("rsv_wr_pend0", pending[0], 1'b1);
        wr(2'd0, 4'b0100);
        rd(2'd0, c_cond_greater_or_equal);
        check_val("legacy_ge", out, 1'b1);

        // Every flag pattern against every code.
        for (int f = 0; f < 16; f++) begin
            wr(2'd0, 4'(f));
            for (int c = 0; c < 16; c++) rd(2'd0, 4'(c));
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        idle();

        // Three-bank instance: select 3 is out of range.
        wr_en3 = 1; wr_sel3 = 2'd3; wr_flags3 = 4'hf;
        rsv_en3 = 1; rsv_sel3 = 2'd3;
        rd_en3 = 1; rd_sel3 = 2'd3; rd_cond3 = c_cond_al;
        #1;
        check_val("oor_stall", stall3, 1'b0);
        @(posedge clk);
        #1;
        check_val("oor_valid", out_valid3, 1'b1);
        check_val("oor_out", out3, 1'b0);
        check_val("oor_pending", pending3, 3'b000);
        @(negedge clk);
        wr_en3 = 0; rsv_en3 = 1; rsv_sel3 = 2'd2;
        rd_en3 = 1; rd_sel3 = 2'd2; rd_cond3 = c_cond_al;
        #1;
        check_val("inr_stall", stall3, 1'b0);
        @(posedge clk);
        #1;
        check_val("inr_valid", out_valid3, 1'b1);
        check_val("inr_out", out3, 1'b1);
        check_val("inr_pending", pending3, 3'b100);
        @(negedge clk);
        rsv_en3 = 0; rd_en3 = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
